// File: rtl/multicycle_seq_pkg.sv
// Shared types and defaults for the multi-cycle instruction sequencer.
package multicycle_seq_pkg;

   // Sequencer states; the numeric values are visible on the debug state port
   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_FETCH  = 3'd1,
      SEQ_DECODE = 3'd2,
      SEQ_EXEC   = 3'd3,
      SEQ_MEM    = 3'd4,
      SEQ_WB     = 3'd5,
      SEQ_HALT   = 3'd6,
      SEQ_ERR    = 3'd7
   } seq_state_t;

   localparam int DEF_TIMEOUT_CYC = 256;
   localparam int DEF_CNT_W       = 32;

   // States in which the sequencer waits on a memory handshake
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == SEQ_FETCH) || (s == SEQ_MEM);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Handshake wait counter: counts not-ready cycles and flags the last allowed one.
module seq_wait_timer #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count;

   // Count not-ready cycles, saturating at the last allowed value
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with handshake timeout.
module multicycle_seq
   import multicycle_seq_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req,
   input  logic             ifu_ready,
   input  logic [31:0]      inst,
   output logic [31:0]      ir,
   input  logic             RegWr,
   input  logic             MemRd,
   input  logic             MemWr,
   input  logic             halt,
   output logic             lsu_req,
   output logic             lsu_we,
   input  logic             lsu_ready,
   output logic             rf_we,
   output logic             pc_we,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             timeout_err,
   output logic [2:0]       state
);

   seq_state_t cur_state;
   seq_state_t nxt_state;
   logic       in_wait;
   logic       ready_sel;
   logic       expired;

   assign state     = cur_state;
   assign in_wait   = is_wait_state(cur_state);
   assign ready_sel = (cur_state == SEQ_FETCH) ? ifu_ready : lsu_ready;

   // The counter is held at zero outside FETCH/MEM so each handshake starts fresh
   seq_wait_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (~in_wait),
      .enable  (in_wait & ~ready_sel),
      .expired (expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_state <= SEQ_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state and strobes; strobes are forced low while reset is asserted
   always_comb begin
      nxt_state = cur_state;
      ifu_req   = 1'b0;
      lsu_req   = 1'b0;
      lsu_we    = 1'b0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;
      case (cur_state)
         SEQ_IDLE:   nxt_state = SEQ_FETCH;
         SEQ_FETCH: begin
            ifu_req = rst;
            if (ifu_ready) begin
               nxt_state = SEQ_DECODE;
            end else if (expired) begin
               nxt_state = SEQ_ERR;
            end
         end
         SEQ_DECODE: nxt_state = SEQ_EXEC;
         SEQ_EXEC:   nxt_state = (MemRd || MemWr) ? SEQ_MEM : SEQ_WB;
         SEQ_MEM: begin
            lsu_req = rst;
            lsu_we  = rst & MemWr;
            if (lsu_ready) begin
               nxt_state = SEQ_WB;
            end else if (expired) begin
               nxt_state = SEQ_ERR;
            end
         end
         SEQ_WB: begin
            rf_we     = rst & RegWr & ~MemWr;
            pc_we     = rst & ~halt;
            nxt_state = halt ? SEQ_HALT : SEQ_FETCH;
         end
         SEQ_HALT:   nxt_state = SEQ_HALT;
         SEQ_ERR:    nxt_state = SEQ_ERR;
         default:    nxt_state = SEQ_ERR;
      endcase
   end

   // Instruction register captures the fetched word when the fetch completes
   always_ff @(posedge clk) begin
      if (!rst) begin
         ir <= 32'h0;
      end else if ((cur_state == SEQ_FETCH) && ifu_ready) begin
         ir <= inst;
      end
   end

   // Retire counter advances once per writeback, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_cnt <= '0;
      end else if (cur_state == SEQ_WB) begin
         retire_cnt <= retire_cnt + 1'b1;
      end
   end

   // Sticky timeout flag, set on the transition into ERR
   always_ff @(posedge clk) begin
      if (!rst) begin
         timeout_err <= 1'b0;
      end else if (nxt_state == SEQ_ERR) begin
         timeout_err <= 1'b1;
      end
   end

endmodule
